// File: rtl/count_stream_pkg.sv
// rtl/count_stream_pkg.sv - shared defaults, widths and beat type for the counter sample stream
package count_stream_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int DROP_W_DEF = 8;

    localparam int PTR_W = $clog2(DEPTH_DEF);
    localparam int LVL_W = $clog2(DEPTH_DEF + 1);

    typedef struct packed {
        logic                 valid;
        logic [WIDTH_DEF-1:0] data;
    } sample_t;

endpackage

// File: rtl/count_stream_if.sv
// rtl/count_stream_if.sv - valid/ready sample stream toward the interconnect
interface count_stream_if #(
    parameter int WIDTH = 8
) ();
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/count_stream_fifo.sv
// rtl/count_stream_fifo.sv - registered FIFO with occupancy; caller guarantees no overflow/underflow
module count_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (level_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o = level_q;

endmodule

// File: rtl/count_stream_tx.sv
// rtl/count_stream_tx.sv - samples the counter on strobe, buffers, streams out, counts drops
module count_stream_tx
    import count_stream_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int DROP_W      = DROP_W_DEF,
    parameter bit CHANGE_ONLY = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    count_stream_if.master             out,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [DROP_W-1:0]          drop_count,
    input  logic                       clr_drop
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic              fifo_valid;
    logic [WIDTH-1:0]  fifo_data;
    logic [LW-1:0]     fifo_level;

    logic              push, pop, accept, drop, full;
    logic              last_vld_q, last_vld_d;
    logic [WIDTH-1:0]  last_data_q, last_data_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    assign full   = (fifo_level == FULL_LVL);
    assign pop    = fifo_valid && out.out_ready;
    assign push   = in_valid && !(CHANGE_ONLY && last_vld_q && (in_data == last_data_q));
    // A simultaneous pop frees the head slot, so a full FIFO can still take the sample.
    assign accept = push && (!full || pop);
    assign drop   = push && !accept;

    always_comb begin
        last_vld_d  = last_vld_q;
        last_data_d = last_data_q;
        if (accept) begin
            last_vld_d  = 1'b1;
            last_data_d = in_data;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (clr_drop)
            drop_d = '0;
        else if (drop && (drop_q != '1))
            drop_d = drop_q + DROP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld_q  <= 1'b0;
            last_data_q <= '0;
            drop_q      <= '0;
        end else begin
            last_vld_q  <= last_vld_d;
            last_data_q <= last_data_d;
            drop_q      <= drop_d;
        end
    end

    count_stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept),
        .push_data_i (in_data),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .data_o      (fifo_data),
        .level_o     (fifo_level)
    );

    assign out.out_valid = fifo_valid;
    assign out.out_data  = fifo_data;
    assign level         = fifo_level;
    assign drop_count    = drop_q;

endmodule

// File: doc/count_stream_tx.md
Name: count_stream_tx

Overview:
Downstream consumer of the 8-bit free-running counter. Samples the counter value on each strobe and buffers samples in a small FIFO. Presents the samples as a valid/ready stream toward the stream interconnect. Tracks samples lost to backpressure in a saturating drop counter, and can optionally suppress repeated values.

Parameters:
WIDTH, 8, sample width; matches the counter output width.
DEPTH, 4, FIFO entries; power of two, >= 2.
DROP_W, 8, width of the saturating drop counter.
CHANGE_ONLY, 0, 1 = push only when the sample differs from the last pushed value.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  sample strobe; tied to the counter's enable.
in_data  in  WIDTH  counter value to sample.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer accepts the head.
out_data  out  WIDTH  FIFO head; 0 when out_valid = 0.
level  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
drop_count  out  DROP_W  samples dropped because the FIFO was full; saturates at all-ones.
clr_drop  in  1  synchronous clear of drop_count.

Behaviour:
- Reset (sync, rst = 1 at a rising edge) forces the following state. Pointers = 0, level = 0, out_valid = 0, out_data = 0, drop_count = 0, last-pushed-valid flag = 0. Storage contents are don't-care. Reset overrides all inputs in the same cycle.
- Push condition: in_valid && !(CHANGE_ONLY && last_vld && in_data == last_data).
- Accept condition: push && (level < DEPTH || pop).
- Pop condition: out_valid && out_ready.
- Latency: a sample accepted at edge t is visible on out_valid/out_data after edge t. There is no combinational in->out bypass.
- Output ordering is strict FIFO order.
- Full with simultaneous push and pop: both happen; level stays at DEPTH.
- Full with push and no pop: the sample is dropped (newest is lost, stored data untouched). drop_count increments unless already all-ones.
- Drops never update last_data.
- Empty with simultaneous push and pop: impossible, since out_valid = 0 and the pop is not counted. The push is stored and level becomes 1.
- level update: +1 on accept without pop, −1 on pop without accept, else unchanged.
- Pointers wrap modulo DEPTH; use one extra bit or the level counter to tell full from empty.
- CHANGE_ONLY:
  - last_data/last_vld update only on an accepted push.
  - The first sample after reset is always pushed.
  - A suppressed sample is neither stored nor counted as a drop.
- clr_drop: takes effect at the next edge. If a drop happens in the same cycle, the clear wins and drop_count = 0.
- Reset mid-operation: all buffered samples are discarded. out_valid falls after the reset edge regardless of out_ready.
- Stream rule: once out_valid = 1, out_data must stay stable until a pop. Only a reset may retract it.

Decomposition:
- Shared package count_stream_pkg:
  - localparam PTR_W = $clog2(DEPTH).
  - localparam LVL_W = $clog2(DEPTH+1).
  - A packed struct {valid, data} for the sample beat.
  - Handshake helpers come from pyc_handshake_pkg.
- One sub-module, count_stream_fifo: a registered FIFO with push/pop/level, no drop logic. The top level owns push qualification, change suppression and the drop counter.
- The standalone output can be bound to pyc_stream_if at integration.

Test Plan:
1. Reset, then in_valid = 1 with in_data 0,1,2 over 3 cycles and out_ready = 1. Expect out_data 0,1,2 on out_valid, one cycle later each; level stays <= 1; drop_count = 0.
2. out_ready = 0, push 6 samples 10..15 with DEPTH = 4. Expect level = 4 and drop_count = 2. Then out_ready = 1: drains 10,11,12,13 in order, then out_valid = 0.
3. Full FIFO with in_valid = 1, in_data = 20 and out_ready = 1 in the same cycle. Expect head popped, 20 stored at the tail, level stays 4, drop_count unchanged.
4. CHANGE_ONLY = 1, inputs 5,5,5,6,6,7 on consecutive cycles with out_ready = 1. Expect output stream 5,6,7 and drop_count = 0.
5. DROP_W = 2, out_ready = 0, push 9 samples into DEPTH 4. Expect drop_count saturates at 3. Then assert clr_drop together with a drop: expect drop_count = 0.
6. FIFO holding 3 samples, assert rst for one cycle while out_ready = 1. Expect after that edge out_valid = 0, level = 0, out_data = 0. The next push appears on the output one cycle later.
